// File: rtl/lab2_proc_fetch_unit.sv
// Instruction fetch unit: credit-limited imem requests, in-order response
// buffering with PCs, and squash handling that drops stale in-flight responses.
module lab2_proc_fetch_unit #(
    parameter int unsigned p_max_inflight = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_val,
    input  logic [31:0] fetch_addr,
    output logic        fetch_rdy,
    output logic        imem_reqstream_val,
    input  logic        imem_reqstream_rdy,
    output logic [31:0] imem_reqstream_msg_addr,
    input  logic        imem_respstream_val,
    output logic        imem_respstream_rdy,
    input  logic [31:0] imem_respstream_msg_data,
    input  logic        squash,
    output logic        inst_val,
    input  logic        inst_rdy,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        drop_pending
);

    localparam int unsigned CW = $clog2(p_max_inflight + 1);
    localparam int unsigned PW = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
    localparam logic [CW:0] MAX_INFLIGHT = (CW + 1)'(p_max_inflight);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(p_max_inflight - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [CW-1:0] live_q, live_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] buf_cnt_q, buf_cnt_d;
    logic [PW-1:0] buf_rd_q, buf_rd_d;
    logic [PW-1:0] buf_wr_q, buf_wr_d;
    logic [PW-1:0] pcf_rd_q, pcf_rd_d;
    logic [PW-1:0] pcf_wr_q, pcf_wr_d;
    logic [31:0]   buf_data_q [p_max_inflight];
    logic [31:0]   buf_data_d [p_max_inflight];
    logic [31:0]   buf_pc_q   [p_max_inflight];
    logic [31:0]   buf_pc_d   [p_max_inflight];
    logic [31:0]   pcf_q      [p_max_inflight];
    logic [31:0]   pcf_d      [p_max_inflight];

    logic        credit;
    logic        fire;
    logic        resp;
    logic        pop;
    logic        buf_push;
    logic [31:0] resp_pc;

    always_comb begin
        credit = (({1'b0, live_q} + {1'b0, drop_q}) < MAX_INFLIGHT) &&
                 (({1'b0, live_q} + {1'b0, buf_cnt_q}) < MAX_INFLIGHT);
        fetch_rdy               = reset && credit && imem_reqstream_rdy;
        imem_reqstream_val      = reset && fetch_val && credit;
        imem_reqstream_msg_addr = fetch_addr;
        imem_respstream_rdy     = reset;
        fire                    = fetch_val && fetch_rdy;
        resp                    = imem_respstream_val && reset;
        inst_val                = (buf_cnt_q != '0) && !squash;
        pop                     = inst_val && inst_rdy;
        inst_data               = buf_data_q[buf_rd_q];
        inst_pc                 = buf_pc_q[buf_rd_q];
        drop_pending            = (drop_q != '0);
    end

    always_comb begin
        live_d     = live_q;
        drop_d     = drop_q;
        buf_cnt_d  = buf_cnt_q;
        buf_rd_d   = buf_rd_q;
        buf_wr_d   = buf_wr_q;
        pcf_rd_d   = pcf_rd_q;
        pcf_wr_d   = pcf_wr_q;
        buf_data_d = buf_data_q;
        buf_pc_d   = buf_pc_q;
        pcf_d      = pcf_q;
        buf_push   = 1'b0;
        // With nothing outstanding, a response can only belong to this cycle's fetch.
        resp_pc    = (live_q == '0 && drop_q == '0) ? fetch_addr : pcf_q[pcf_rd_q];

        if (fire) begin
            pcf_d[pcf_wr_q] = fetch_addr;
            pcf_wr_d        = ptr_inc(pcf_wr_q);
        end
        if (resp) begin
            pcf_rd_d = ptr_inc(pcf_rd_q);
        end

        if (squash) begin
            drop_d    = drop_q + live_q - CW'(resp);
            live_d    = CW'(fire);
            buf_cnt_d = '0;
            buf_rd_d  = '0;
            buf_wr_d  = '0;
        end else begin
            buf_push = resp && (drop_q == '0);
            if (resp && !buf_push) begin
                drop_d = drop_q - CW'(1);
            end
            live_d = live_q + CW'(fire) - CW'(buf_push);
            if (buf_push) begin
                buf_data_d[buf_wr_q] = imem_respstream_msg_data;
                buf_pc_d[buf_wr_q]   = resp_pc;
                buf_wr_d             = ptr_inc(buf_wr_q);
            end
            if (pop) begin
                buf_rd_d = ptr_inc(buf_rd_q);
            end
            buf_cnt_d = buf_cnt_q + CW'(buf_push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q    <= '0;
            drop_q    <= '0;
            buf_cnt_q <= '0;
            buf_rd_q  <= '0;
            buf_wr_q  <= '0;
            pcf_rd_q  <= '0;
            pcf_wr_q  <= '0;
            for (int unsigned i = 0; i < p_max_inflight; i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
                pcf_q[i]      <= '0;
            end
        end else begin
            live_q     <= live_d;
            drop_q     <= drop_d;
            buf_cnt_q  <= buf_cnt_d;
            buf_rd_q   <= buf_rd_d;
            buf_wr_q   <= buf_wr_d;
            pcf_rd_q   <= pcf_rd_d;
            pcf_wr_q   <= pcf_wr_d;
            buf_data_q <= buf_data_d;
            buf_pc_q   <= buf_pc_d;
            pcf_q      <= pcf_d;
        end
    end

    buf_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(buf_push && !pop && buf_cnt_q == CW'(p_max_inflight)));

endmodule

// File: tb/tb_lab2_proc_fetch_unit.sv
// Bench for lab2_proc_fetch_unit: directed scenarios plus random traffic checked
// against a request-queue reference model and an in-order memory model.
module tb_lab2_proc_fetch_unit;

    localparam int unsigned P = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_val;
    logic [31:0] fetch_addr;
    logic        fetch_rdy;
    logic        imem_reqstream_val;
    logic        imem_reqstream_rdy;
    logic [31:0] imem_reqstream_msg_addr;
    logic        imem_respstream_val;
    logic        imem_respstream_rdy;
    logic [31:0] imem_respstream_msg_data;
    logic        squash;
    logic        inst_val;
    logic        inst_rdy;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        drop_pending;

    lab2_proc_fetch_unit #(.p_max_inflight(P)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .fetch_val                (fetch_val),
        .fetch_addr               (fetch_addr),
        .fetch_rdy                (fetch_rdy),
        .imem_reqstream_val       (imem_reqstream_val),
        .imem_reqstream_rdy       (imem_reqstream_rdy),
        .imem_reqstream_msg_addr  (imem_reqstream_msg_addr),
        .imem_respstream_val      (imem_respstream_val),
        .imem_respstream_rdy      (imem_respstream_rdy),
        .imem_respstream_msg_data (imem_respstream_msg_data),
        .squash                   (squash),
        .inst_val                 (inst_val),
        .inst_rdy                 (inst_rdy),
        .inst_data                (inst_data),
        .inst_pc                  (inst_pc),
        .drop_pending             (drop_pending)
    );

    always #5 clk = ~clk;

    // Each outstanding request carries its PC and whether a squash has killed it.
    typedef struct { logic [31:0] pc; bit live; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int unsigned due; } mem_t;

    req_t        oq[$];
    ent_t        bq[$];
    mem_t        mq[$];
    logic [31:0] dlog[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned fires  = 0;

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a3c_9e17;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic step(input bit fv, input logic [31:0] fa, input bit rrdy, input bit ir,
                        input bit sq, input int unsigned lat, output bit fired);
        int unsigned lv;
        int unsigned due;
        bit          dead;
        bit          credit;
        bit          resp;
        bit          byp;
        bit          exp_iv;
        logic [31:0] raddr;
        req_t        o;

        lv = 0;
        dead = 1'b0;
        foreach (oq[i]) begin
            if (oq[i].live) lv++;
            else dead = 1'b1;
        end
        credit = (oq.size() < P) && (lv + bq.size() < P);
        fired  = fv && credit && rrdy;
        resp   = 1'b0;
        byp    = 1'b0;
        raddr  = '0;
        if (mq.size() != 0) begin
            if (mq[0].due <= cyc) begin
                resp  = 1'b1;
                raddr = mq[0].addr;
            end
        end else if (fired && lat == 0) begin
            resp  = 1'b1;
            byp   = 1'b1;
            raddr = fa;
        end

        fetch_val                = fv;
        fetch_addr               = fa;
        imem_reqstream_rdy       = rrdy;
        inst_rdy                 = ir;
        squash                   = sq;
        imem_respstream_val      = resp;
        imem_respstream_msg_data = resp ? memdata(raddr) : $urandom;
        #1;

        exp_iv = (bq.size() != 0) && !sq;
        chk("fetch_rdy", {31'b0, fetch_rdy}, {31'b0, credit && rrdy});
        chk("req_val", {31'b0, imem_reqstream_val}, {31'b0, fv && credit});
        chk("req_addr", imem_reqstream_msg_addr, fa);
        chk("resp_rdy", {31'b0, imem_respstream_rdy}, 32'd1);
        chk("inst_val", {31'b0, inst_val}, {31'b0, exp_iv});
        chk("drop_pending", {31'b0, drop_pending}, {31'b0, dead});
        if (exp_iv) begin
            chk("inst_pc", inst_pc, bq[0].pc);
            chk("inst_data", inst_data, bq[0].data);
        end
        if (inst_val && ir) dlog.push_back(inst_pc);

        if (sq) begin
            foreach (oq[i]) oq[i].live = 1'b0;
            bq.delete();
        end else if (exp_iv && ir) begin
            void'(bq.pop_front());
        end
        if (fired) begin
            oq.push_back('{fa, 1'b1});
            fires++;
        end
        if (resp) begin
            o = oq.pop_front();
            if (o.live && !sq) bq.push_back('{o.pc, memdata(raddr)});
        end

        if (resp && !byp) void'(mq.pop_front());
        if (fired && !byp) begin
            due = cyc + lat;
            if (mq.size() != 0 && mq[$].due > due) due = mq[$].due;
            mq.push_back('{fa, due});
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int unsigned n);
        bit f;
        for (int unsigned i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1, f);
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_inst_val", {31'b0, inst_val}, 32'd0);
        chk("rst_req_val", {31'b0, imem_reqstream_val}, 32'd0);
        chk("rst_fetch_rdy", {31'b0, fetch_rdy}, 32'd0);
        chk("rst_drop_pending", {31'b0, drop_pending}, 32'd0);
        chk("rst_resp_rdy", {31'b0, imem_respstream_rdy}, 32'd0);
        oq.delete();
        bq.delete();
        mq.delete();
        imem_respstream_val = 1'b0;
        squash = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        chk("rst_hold_inst_val", {31'b0, inst_val}, 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] pc;
        bit          f;
        bit          got;

        reset                    = 1'b0;
        fetch_val                = 1'b1;
        fetch_addr               = 32'h200;
        imem_reqstream_rdy       = 1'b1;
        imem_respstream_val      = 1'b0;
        imem_respstream_msg_data = '0;
        squash                   = 1'b0;
        inst_rdy                 = 1'b1;
        #1;
        chk("por_inst_val", {31'b0, inst_val}, 32'd0);
        chk("por_req_val", {31'b0, imem_reqstream_val}, 32'd0);
        chk("por_fetch_rdy", {31'b0, fetch_rdy}, 32'd0);
        chk("por_resp_rdy", {31'b0, imem_respstream_rdy}, 32'd0);
        chk("por_drop_pending", {31'b0, drop_pending}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Streaming with a zero-latency memory
        dlog.delete();
        step(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 0, f);
        step(1'b1, 32'h204, 1'b1, 1'b1, 1'b0, 0, f);
        step(1'b1, 32'h208, 1'b1, 1'b1, 1'b0, 0, f);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 0, f);
        chk("stream_count", dlog.size(), 32'd3);
        if (dlog.size() == 3) begin
            chk("stream_pc0", dlog[0], 32'h200);
            chk("stream_pc1", dlog[1], 32'h204);
            chk("stream_pc2", dlog[2], 32'h208);
        end
        idle(2);

        // Credit limit with a slow memory and a stalled D stage
        dlog.delete();
        fires = 0;
        pc = 32'h200;
        for (int unsigned i = 0; i < 10; i++) begin
            step(1'b1, pc, 1'b1, 1'b0, 1'b0, 5, f);
            if (f) pc += 32'd4;
        end
        chk("credit_fires", fires, 32'd2);
        chk("credit_fetch_rdy", {31'b0, fetch_rdy}, 32'd0);
        for (int unsigned i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 5, f);
        chk("credit_count", dlog.size(), 32'd2);
        if (dlog.size() == 2) begin
            chk("credit_pc0", dlog[0], 32'h200);
            chk("credit_pc1", dlog[1], 32'h204);
        end
        idle(2);

        // Squash with two requests in flight
        step(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 5, f);
        step(1'b1, 32'h204, 1'b1, 1'b1, 1'b0, 5, f);
        step(1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 5, f);
        chk("sq_drop_pending", {31'b0, drop_pending}, 32'd1);
        dlog.delete();
        got = f;
        for (int unsigned i = 0; i < 20; i++) begin
            if (!got) begin
                step(1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 5, f);
                got = f;
            end else begin
                step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 5, f);
            end
        end
        chk("sq_target_fired", {31'b0, got}, 32'd1);
        chk("sq_delivered", dlog.size(), 32'd1);
        if (dlog.size() != 0) chk("sq_first_pc", dlog[0], 32'h300);

        // Response arriving in the squash cycle
        dlog.delete();
        step(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 2, f);
        step(1'b1, 32'h204, 1'b1, 1'b1, 1'b0, 2, f);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2, f);
        chk("sqr_drop_pending_1", {31'b0, drop_pending}, 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 2, f);
        chk("sqr_drop_pending_0", {31'b0, drop_pending}, 32'd0);
        chk("sqr_inst_val", {31'b0, inst_val}, 32'd0);
        idle(3);
        chk("sqr_delivered", dlog.size(), 32'd0);

        // Full buffer, stalled D, then squash
        step(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1, f);
        step(1'b1, 32'h204, 1'b1, 1'b0, 1'b0, 1, f);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1, f);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1, f);
        chk("flush_pre_inst_val", {31'b0, inst_val}, 32'd1);
        dlog.delete();
        step(1'b1, 32'h400, 1'b1, 1'b0, 1'b1, 1, f);
        chk("flush_post_inst_val", {31'b0, inst_val}, 32'd0);
        got = f;
        for (int unsigned i = 0; i < 10; i++) begin
            if (!got) begin
                step(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1, f);
                got = f;
            end else begin
                step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1, f);
            end
        end
        chk("flush_delivered", dlog.size(), 32'd1);
        if (dlog.size() != 0) chk("flush_first_pc", dlog[0], 32'h400);

        // Asynchronous reset mid-stream, then a clean restart
        step(1'b1, 32'h500, 1'b1, 1'b1, 1'b0, 2, f);
        step(1'b1, 32'h504, 1'b1, 1'b1, 1'b0, 2, f);
        step(1'b1, 32'h508, 1'b1, 1'b1, 1'b0, 2, f);
        async_reset();
        dlog.delete();
        step(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 0, f);
        step(1'b1, 32'h204, 1'b1, 1'b1, 1'b0, 0, f);
        step(1'b1, 32'h208, 1'b1, 1'b1, 1'b0, 0, f);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 0, f);
        chk("rst_restart_count", dlog.size(), 32'd3);
        if (dlog.size() == 3) begin
            chk("rst_restart_pc0", dlog[0], 32'h200);
            chk("rst_restart_pc2", dlog[2], 32'h208);
        end

        // Random traffic
        pc = 32'h1000;
        for (int unsigned i = 0; i < 800; i++) begin
            bit          fv;
            bit          rr;
            bit          ir;
            bit          sq;
            int unsigned lat;
            fv  = ($urandom % 4) != 0;
            rr  = ($urandom % 4) != 0;
            ir  = ($urandom % 10) < 7;
            sq  = ($urandom % 16) == 0;
            lat = sq ? $urandom_range(1, 4) : $urandom_range(0, 4);
            step(fv, pc, rr, ir, sq, lat, f);
            if (sq) pc = {$urandom_range(0, 16'hffff), 16'h0} | {20'h0, $urandom_range(0, 255), 2'b00};
            else if (f) pc += 32'd4;
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lab2_proc_fetch_unit.md
# lab2_proc_fetch_unit

Instruction fetch unit for the pipelined processor, sitting between F-stage PC selection and the D-stage instruction register. It issues imem requests for the PC chosen by the control unit and bounds the number of outstanding requests with credits. It buffers in-order imem responses together with their PCs and presents them to D through a val/rdy interface. On a redirect (squash) it discards every older buffered or in-flight response, so the D stage never sees a wrong-path instruction.

## Interface
- p_max_inflight, 2: maximum outstanding imem requests, live plus dropped; legal range 1..4. It is also the depth of the instruction buffer and of the PC FIFO.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset: asserted when 0, and state clears immediately. Deassertion is synchronous to clk.
- fetch_val  in  1  control requests a fetch of fetch_addr this cycle.
- fetch_addr  in  32  PC to fetch, normally pc_next_F.
- fetch_rdy  out  1  fetch accepted; a fetch fires when fetch_val && fetch_rdy.
- imem_reqstream_val  out  1  imem request valid.
- imem_reqstream_rdy  in  1  imem ready.
- imem_reqstream_msg_addr  out  32  equals fetch_addr (combinational).
- imem_respstream_val  in  1  imem response valid; responses return in request order.
- imem_respstream_rdy  out  1  always 1 while reset is deasserted.
- imem_respstream_msg_data  in  32  instruction word.
- squash  in  1  redirect pulse; kills all older outstanding and buffered instructions.
- inst_val  out  1  buffered instruction available to D.
- inst_rdy  in  1  D accepts, i.e. reg_en_D.
- inst_data  out  32  head instruction.
- inst_pc  out  32  PC of the head instruction.
- drop_pending  out  1  drop_cnt != 0.

## Operation
**State**
- live_cnt: outstanding, non-squashed requests.
- drop_cnt: outstanding, squashed requests.
- Instruction buffer: circular FIFO holding {data, pc}, with occupancy buf_cnt.
- PC FIFO: one entry per outstanding request, live or dropped.

**Request path**
- credit = (live_cnt + drop_cnt < p_max_inflight) && (live_cnt + buf_cnt < p_max_inflight).
- imem_reqstream_val = fetch_val && credit.
- fetch_rdy = credit && imem_reqstream_rdy.
- On a fire, fetch_addr is pushed into the PC FIFO and live_cnt increments.

**Response path**
- Every response pops the PC FIFO.
- If drop_cnt > 0, or squash is asserted in the same cycle, the response is discarded and counted against the drops.
- Otherwise {data, popped pc} is written to the buffer tail and live_cnt decrements.
- Buffer overflow is impossible by construction of credit; an overflow triggers a simulation assertion.

**D interface**
- inst_val = (buf_cnt != 0) && !squash.
- The head pops when inst_val && inst_rdy.

**Squash (cycle t)**
- The buffer is flushed: buf_cnt becomes 0.
- drop_cnt(t+1) = drop_cnt + live_cnt − (response arriving in cycle t ? 1 : 0). A response arriving in cycle t is discarded: it first consumes an existing drop if one exists, otherwise it consumes a live request.
- live_cnt(t+1) = 1 if a request fires in cycle t (that fetch is the redirect target and is live), else 0.

**Simultaneous events**
- A request fire, a response and a D pop in the same cycle all take effect; the counters net correctly.
- A push and a pop on a single-entry buffer in the same cycle are legal.

**Arithmetic**
- Counters are $clog2(p_max_inflight+1) bits wide.
- FIFO pointers wrap modulo p_max_inflight.

**Reset**
- live_cnt = drop_cnt = buf_cnt = 0; pointers = 0.
- inst_val = 0, imem_reqstream_val = 0, fetch_rdy = 0, imem_respstream_rdy = 0, drop_pending = 0.
- Asserting reset mid-operation abandons all outstanding state; the bench must also reset the memory model.

## Timing
- Request: combinational from fetch_val/fetch_addr, with zero added latency.
- Response to D: registered. A response accepted in cycle t shows inst_val=1 at t+1; there is no bypass.
- Best case with a 0-cycle memory: fetch fires at t, inst_val at t+1. Full throughput is one instruction per cycle when p_max_inflight ≥ 2.
- squash to inst_val low: same cycle (combinational).
- First live instruction after a squash: one cycle after its own response, at the earliest.
- drop_pending falls the cycle after the last dropped response is consumed.

## Test plan
- **Streaming:** after reset, fetch 0x200, 0x204, 0x208 with a 0-cycle memory and inst_rdy=1. Required: inst_pc 0x200/0x204/0x208 on consecutive cycles starting 1 cycle after the first response, with data matching memory.
- **Credit limit:** p_max_inflight=2, memory latency 5, inst_rdy=0. Required: exactly 2 fetches fire; fetch_rdy stays 0 until D pops; no response is lost.
- **Squash with in-flight requests:** 2 requests outstanding (0x200, 0x204), squash with a simultaneous fetch of 0x300. Required: drop_cnt=2 and drop_pending=1; 0x200/0x204 are discarded; first inst_pc is 0x300.
- **Response arriving on squash:** response for 0x200 arrives in the squash cycle with 0x204 still live. Required: both discarded; drop_cnt=1 then 0; buffer empty.
- **Buffered flush plus back-pressure:** buffer holds 2 entries, D stalls, then squash. Required: inst_val=0 in the squash cycle and after; next delivered PC is the redirect target.
- **Async reset:** drive reset low mid-stream, off a clock edge. Required: inst_val, imem_reqstream_val and the counters go to 0 immediately; after release, fetching from 0x200 restarts cleanly.
